memory_access_unit: RTL and testbench
=====================================

MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 Parameter ADDR_BITS, default 16, word-index width passed to data memory (address bits above it ignored or checked).
REQ-002 Parameter DST_W, default 6, register destination tag width.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 req_valid  in  1  upstream (execute stage) presents a memory request.
REQ-006 req_ready  out  1  unit accepts request on posedge when req_valid & req_ready.
REQ-007 req_rd / req_wrt  in  1 each  load / store request flags.
REQ-008 req_addr  in  32  word address (ALU result); req_wdata  in  32  store data.
REQ-009 req_dst  in  DST_W  load destination register tag.
REQ-010 mem_rd / mem_wrt  out  1 each  data-memory read/write strobes.
REQ-011 mem_addr  out  32  data-memory address; mem_datain  out  32  store data.
REQ-012 mem_dataout  in  32  data-memory read data, valid after the negedge of the access cycle.
REQ-013 wb_valid  out  1  one-cycle write-back pulse; wb_regwrt  out  1  write register file.
REQ-014 wb_dst  out  DST_W; wb_data  out  32  write-back tag and data.
REQ-015 fault  out  1  one-cycle pulse coincident with wb_valid for a rejected access.

Function
REQ-016 FSM states IDLE, ACCESS, RESP; req_ready = 1 only in IDLE.
REQ-017 IDLE: on req_valid, register addr/wdata/dst/rd/wrt, go ACCESS; else stay IDLE.
REQ-018 ACCESS: mem_rd = latched rd, mem_wrt = latched wrt, mem_addr = {zeros, latched addr[ADDR_BITS-1:0]}, mem_datain = latched wdata; memory completes at the negedge inside this cycle.
REQ-019 ACCESS -> RESP unconditionally; on that posedge capture mem_dataout into wb_data if latched rd, else wb_data = 0.
REQ-020 RESP: wb_valid = 1, wb_regwrt = latched rd, wb_dst = latched dst; mem_rd = mem_wrt = 0; -> IDLE.
REQ-021 Latency: request accepted at edge N, wb_valid high in cycle N+2; throughput one request per 3 cycles.
REQ-022 Strobes mem_rd/mem_wrt are high only in ACCESS, never in IDLE or RESP.
REQ-023 rd = wrt = 0: passes through all states, strobes stay low, wb_valid = 1, wb_regwrt = 0.
REQ-024 rd = wrt = 1: both strobes asserted; memory writes then reads, so wb_data = req_wdata, wb_regwrt = 1.
REQ-025 req inputs are ignored outside IDLE; upstream holds them until accepted.

Reset
REQ-026 On rst: state = IDLE, all outputs 0 except req_ready = 1, latched fields 0, on the same posedge.
REQ-027 rst in ACCESS: the store already committed at that cycle's negedge is not undone; the response is dropped (no wb_valid).
REQ-028 rst in RESP: wb_valid drops at that posedge; the response is lost.

Configuration
REQ-029 Macro MEMACC_BOUNDS_CHECK_EN defined: request with req_addr[31:ADDR_BITS] != 0 keeps both strobes low in ACCESS, and RESP drives fault = 1, wb_regwrt = 0, wb_data = 0.
REQ-030 Macro undefined: upper address bits silently truncated; fault tied to 0; no check logic synthesized.

Verification
REQ-031 Reset then idle 5 cycles -> req_ready = 1, all strobes 0, wb_valid = 0 throughout.
REQ-032 Store addr 7 data 0x0000002A, then load addr 7 dst 5 -> load wb_valid at accept+2 with wb_data = 0x2A, wb_dst = 5, wb_regwrt = 1; store gives wb_regwrt = 0.
REQ-033 req_valid held high with back-to-back requests -> req_ready low for 2 cycles after each accept; held inputs not re-sampled until IDLE.
REQ-034 Load addr 3 of preloaded value 0xFFFFFFFC -> wb_data = 0xFFFFFFFC, mem_rd high for exactly one cycle.
REQ-035 rst asserted in ACCESS of a store to addr 9 (data 0x11) -> no wb_valid; later load of addr 9 returns 0x11.
REQ-036 With MEMACC_BOUNDS_CHECK_EN, store to 0x00010004 -> mem_wrt never high, fault = wb_valid = 1, addr 4 unchanged; without macro, addr 4 is written.

Source files
------------

// File: rtl/memory_access_unit_if.sv
// Bus bundle for the memory access unit: request handshake from execute,
// data-memory strobes/data, and the write-back response.
// The slave modport is the unit; the master modport is upstream plus memory.
interface memory_access_unit_if #(
  parameter int DST_W = 6
);
  logic             req_valid;
  logic             req_ready;
  logic             req_rd;
  logic             req_wrt;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic [DST_W-1:0] req_dst;
  logic             mem_rd;
  logic             mem_wrt;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_datain;
  logic [31:0]      mem_dataout;
  logic             wb_valid;
  logic             wb_regwrt;
  logic [DST_W-1:0] wb_dst;
  logic [31:0]      wb_data;
  logic             fault;

  modport slave (
    input  req_valid, req_rd, req_wrt, req_addr, req_wdata, req_dst, mem_dataout,
    output req_ready, mem_rd, mem_wrt, mem_addr, mem_datain,
           wb_valid, wb_regwrt, wb_dst, wb_data, fault
  );

  modport master (
    output req_valid, req_rd, req_wrt, req_addr, req_wdata, req_dst, mem_dataout,
    input  req_ready, mem_rd, mem_wrt, mem_addr, mem_datain,
           wb_valid, wb_regwrt, wb_dst, wb_data, fault
  );
endinterface

// File: rtl/memory_access_unit.sv
// Memory access unit: three-state (IDLE/ACCESS/RESP) load/store sequencer
// between execute and a data memory that completes on the negedge of the
// access cycle. All outputs are registered.
// Optional feature: define MEMACC_BOUNDS_CHECK_EN to reject requests whose
// address has bits set above ADDR_BITS (strobes suppressed, fault pulse).
module memory_access_unit #(
  parameter int ADDR_BITS = 16,
  parameter int DST_W     = 6
) (
  input logic                clk,
  input logic                rst,
  memory_access_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  // Word-index mask; a full 32-bit index keeps every address bit.
  localparam logic [31:0] ADDR_MASK = (ADDR_BITS >= 32) ? 32'hFFFF_FFFF
                                      : ((32'h1 << ADDR_BITS) - 32'h1);

  state_t           state;
  logic             lat_rd;
  logic [DST_W-1:0] lat_dst;

`ifdef MEMACC_BOUNDS_CHECK_EN
  logic lat_oob;
  logic req_oob;
  // Any address bit above the word index marks the access as rejected.
  assign req_oob = |(bus.req_addr & ~ADDR_MASK);
`else
  assign bus.fault = 1'b0;
`endif

  // Sequencer: accept in IDLE, strobe memory in ACCESS, pulse write-back in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      lat_rd         <= 1'b0;
      lat_dst        <= '0;
      bus.req_ready  <= 1'b1;
      bus.mem_rd     <= 1'b0;
      bus.mem_wrt    <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_datain <= '0;
      bus.wb_valid   <= 1'b0;
      bus.wb_regwrt  <= 1'b0;
      bus.wb_dst     <= '0;
      bus.wb_data    <= '0;
`ifdef MEMACC_BOUNDS_CHECK_EN
      lat_oob        <= 1'b0;
      bus.fault      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            state          <= ACCESS;
            bus.req_ready  <= 1'b0;
            lat_rd         <= bus.req_rd;
            lat_dst        <= bus.req_dst;
            bus.mem_addr   <= bus.req_addr & ADDR_MASK;
            bus.mem_datain <= bus.req_wdata;
`ifdef MEMACC_BOUNDS_CHECK_EN
            lat_oob        <= req_oob;
            bus.mem_rd     <= bus.req_rd  & ~req_oob;
            bus.mem_wrt    <= bus.req_wrt & ~req_oob;
`else
            bus.mem_rd     <= bus.req_rd;
            bus.mem_wrt    <= bus.req_wrt;
`endif
          end
        end
        ACCESS: begin
          // Memory finished at this cycle's negedge; read data is stable here.
          state          <= RESP;
          bus.mem_rd     <= 1'b0;
          bus.mem_wrt    <= 1'b0;
          bus.mem_addr   <= '0;
          bus.mem_datain <= '0;
          bus.wb_valid   <= 1'b1;
          bus.wb_dst     <= lat_dst;
`ifdef MEMACC_BOUNDS_CHECK_EN
          bus.fault      <= lat_oob;
          bus.wb_regwrt  <= lat_rd & ~lat_oob;
          bus.wb_data    <= (lat_rd & ~lat_oob) ? bus.mem_dataout : 32'h0;
`else
          bus.wb_regwrt  <= lat_rd;
          bus.wb_data    <= lat_rd ? bus.mem_dataout : 32'h0;
`endif
        end
        RESP: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
          bus.wb_valid  <= 1'b0;
          bus.wb_regwrt <= 1'b0;
          bus.wb_dst    <= '0;
          bus.wb_data   <= '0;
`ifdef MEMACC_BOUNDS_CHECK_EN
          bus.fault     <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit with a negedge data-memory model
// (write before read in the same access).
module tb_memory_access_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_rd   = 0;
  int   n_wrt  = 0;

  logic [31:0] mem [0:65535];

  memory_access_unit_if #(.DST_W(6)) bus ();

  memory_access_unit #(.ADDR_BITS(16), .DST_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Data memory: commits store then returns read data on the negedge.
  always @(negedge clk) begin
    if (bus.mem_wrt) begin
      mem[bus.mem_addr[15:0]] = bus.mem_datain;
      n_wrt = n_wrt + 1;
    end
    if (bus.mem_rd) begin
      bus.mem_dataout <= mem[bus.mem_addr[15:0]];
      n_rd = n_rd + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction from IDLE, checking handshake timing on the way.
  task automatic xact(input logic rd, input logic wrt, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [5:0] dst,
                      output logic [31:0] d, output logic rw, output logic [5:0] wd,
                      output logic flt, output int nr, output int nw);
    int rd0;
    int wr0;
    int w;
    rd0 = n_rd;
    wr0 = n_wrt;
    w   = 0;
    bus.req_rd    = rd;
    bus.req_wrt   = wrt;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_dst   = dst;
    bus.req_valid = 1'b1;
    while (!bus.req_ready && w < 10) begin
      step();
      w++;
    end
    chk("accept_wait", {31'b0, bus.req_ready}, 32'd1);
    step();
    bus.req_valid = 1'b0;
    chk("ready_access", {31'b0, bus.req_ready}, 32'd0);
    chk("wbv_access", {31'b0, bus.wb_valid}, 32'd0);
    step();
    chk("wbv_resp", {31'b0, bus.wb_valid}, 32'd1);
    chk("ready_resp", {31'b0, bus.req_ready}, 32'd0);
    chk("strobe_resp", {30'b0, bus.mem_rd, bus.mem_wrt}, 32'd0);
    d   = bus.wb_data;
    rw  = bus.wb_regwrt;
    wd  = bus.wb_dst;
    flt = bus.fault;
    step();
    chk("wbv_idle", {31'b0, bus.wb_valid}, 32'd0);
    chk("ready_idle", {31'b0, bus.req_ready}, 32'd1);
    nr = n_rd - rd0;
    nw = n_wrt - wr0;
  endtask

  initial begin
    logic [31:0] d;
    logic        rw;
    logic        flt;
    logic [5:0]  wd;
    int          nr;
    int          nw;

    mem[3] = 32'hFFFF_FFFC;
    mem[4] = 32'h0000_5555;
    bus.req_valid   = 1'b0;
    bus.req_rd      = 1'b0;
    bus.req_wrt     = 1'b0;
    bus.req_addr    = '0;
    bus.req_wdata   = '0;
    bus.req_dst     = '0;
    bus.mem_dataout = '0;

    // Reset and idle
    step();
    step();
    rst = 1'b0;
    chk("rst_fault", {31'b0, bus.fault}, 32'd0);
    chk("rst_wbdata", bus.wb_data, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_ready", {31'b0, bus.req_ready}, 32'd1);
      chk("idle_strobes", {30'b0, bus.mem_rd, bus.mem_wrt}, 32'd0);
      chk("idle_wbv", {31'b0, bus.wb_valid}, 32'd0);
    end

    // Store then load
    xact(1'b0, 1'b1, 32'd7, 32'h0000_002A, 6'd0, d, rw, wd, flt, nr, nw);
    chk("st_regwrt", {31'b0, rw}, 32'd0);
    chk("st_wrt_cycles", nw, 32'd1);
    chk("st_rd_cycles", nr, 32'd0);
    xact(1'b1, 1'b0, 32'd7, 32'h0, 6'd5, d, rw, wd, flt, nr, nw);
    chk("ld7_data", d, 32'h0000_002A);
    chk("ld7_dst", {26'b0, wd}, 32'd5);
    chk("ld7_regwrt", {31'b0, rw}, 32'd1);

    // Preloaded negative value
    xact(1'b1, 1'b0, 32'd3, 32'h0, 6'd2, d, rw, wd, flt, nr, nw);
    chk("ld3_data", d, 32'hFFFF_FFFC);
    chk("ld3_rd_cycles", nr, 32'd1);

    // Neither read nor write
    xact(1'b0, 1'b0, 32'd3, 32'h0, 6'd4, d, rw, wd, flt, nr, nw);
    chk("nop_regwrt", {31'b0, rw}, 32'd0);
    chk("nop_strobes", nr + nw, 32'd0);
    chk("nop_data", d, 32'd0);

    // Read and write together returns the stored data
    xact(1'b1, 1'b1, 32'd20, 32'h0000_1234, 6'd9, d, rw, wd, flt, nr, nw);
    chk("rw_data", d, 32'h0000_1234);
    chk("rw_regwrt", {31'b0, rw}, 32'd1);
    chk("rw_dst", {26'b0, wd}, 32'd9);

    // Back-to-back with req_valid held; inputs change while busy
    bus.req_rd = 1'b1; bus.req_wrt = 1'b0; bus.req_addr = 32'd7; bus.req_dst = 6'd1;
    bus.req_valid = 1'b1;
    step();
    chk("b2b_ready1", {31'b0, bus.req_ready}, 32'd0);
    chk("b2b_addr1", bus.mem_addr, 32'd7);
    bus.req_addr = 32'd3;
    step();
    chk("b2b_ready2", {31'b0, bus.req_ready}, 32'd0);
    chk("b2b_data1", bus.wb_data, 32'h0000_002A);
    step();
    chk("b2b_ready3", {31'b0, bus.req_ready}, 32'd1);
    step();
    chk("b2b_addr2", bus.mem_addr, 32'd3);
    bus.req_valid = 1'b0;
    step();
    chk("b2b_data2", bus.wb_data, 32'hFFFF_FFFC);
    step();

    // Reset during ACCESS of a store
    bus.req_rd = 1'b0; bus.req_wrt = 1'b1; bus.req_addr = 32'd9; bus.req_wdata = 32'h11;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    chk("rsta_acc", {31'b0, bus.mem_wrt}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rsta_wbv", {31'b0, bus.wb_valid}, 32'd0);
    chk("rsta_ready", {31'b0, bus.req_ready}, 32'd1);
    step();
    chk("rsta_wbv2", {31'b0, bus.wb_valid}, 32'd0);
    xact(1'b1, 1'b0, 32'd9, 32'h0, 6'd3, d, rw, wd, flt, nr, nw);
    chk("rsta_ld9", d, 32'h0000_0011);

    // Reset during RESP
    bus.req_rd = 1'b1; bus.req_wrt = 1'b0; bus.req_addr = 32'd9; bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    step();
    chk("rstr_wbv_before", {31'b0, bus.wb_valid}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstr_wbv_after", {31'b0, bus.wb_valid}, 32'd0);
    chk("rstr_ready", {31'b0, bus.req_ready}, 32'd1);

    // Out-of-range address
    xact(1'b0, 1'b1, 32'h0001_0004, 32'h0000_BEEF, 6'd0, d, rw, wd, flt, nr, nw);
`ifdef MEMACC_BOUNDS_CHECK_EN
    chk("oob_fault", {31'b0, flt}, 32'd1);
    chk("oob_wrt_cycles", nw, 32'd0);
    chk("oob_mem4", mem[4], 32'h0000_5555);
`else
    chk("oob_fault", {31'b0, flt}, 32'd0);
    chk("oob_wrt_cycles", nw, 32'd1);
    chk("oob_mem4", mem[4], 32'h0000_BEEF);
`endif
    chk("oob_regwrt", {31'b0, rw}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
